mult_m2: RTL and testbench
==========================

MULT_M2 -- requirements
Module: mult_m2

Interface
REQ-001 Parameter DATA_W, default `REG_SIZE (32), architectural result width.
REQ-002 Parameter ADDR_W, default `REG_ADDR (5), destination register index width.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 we  in  1  stage enable; 0 = stall, all state holds.
REQ-006 flush  in  1  kill the op entering the stage this edge.
REQ-007 valid_in  in  1  M1 holds a valid multiply op.
REQ-008 regwrite_mult_in  in  1  op writes the register file.
REQ-009 wreg_in  in  ADDR_W  destination register.
REQ-010 pp_ll, pp_lh, pp_hl, pp_hh  in  DATA_W each  unsigned 16x16 partial products of operand magnitudes (lo*lo, lo*hi, hi*lo, hi*hi).
REQ-011 neg_in  in  1  final product is negative (operand signs differ).
REQ-012 valid_out  out  1  stage register holds a valid op.
REQ-013 regwrite_out  out  1  write permission forwarded to M3.
REQ-014 pre_m2result  out  DATA_W  low word of signed product.
REQ-015 pre_zero  out  1  pre_m2result == 0.
REQ-016 pre_overflow  out  1  product does not fit in DATA_W signed.
REQ-017 dst_reg  out  ADDR_W  destination register forwarded to M3.
REQ-018 busy_dst  out  1  valid_out & regwrite_out, for hazard detection against dst_reg.
REQ-019 op_cnt  out  16  count of ops accepted by the stage.

Function
REQ-020 The block SHALL compute, combinationally from inputs, mag = (pp_hh << 32) + ((pp_lh + pp_hl) << 16) + pp_ll in 2*DATA_W bits, with the 33-bit middle-term carry preserved.
REQ-021 The block SHALL form full = neg_in ? (~mag + 1) : mag, modulo 2^(2*DATA_W).
REQ-022 Overflow SHALL be 1 when full[63:32] != {32{full[31]}}; zero SHALL be 1 when full[31:0] == 0.
REQ-023 Latency SHALL be exactly one clk edge with we=1 from inputs to registered outputs.
REQ-024 Accept condition: we=1, valid_in=1, flush=0; on accept, pre_m2result<=full[31:0], pre_zero, pre_overflow, dst_reg<=wreg_in, regwrite_out<=regwrite_mult_in, valid_out<=1.
REQ-025 With we=1, valid_in=0, flush=0: valid_out<=0, regwrite_out<=0; data outputs (pre_m2result, pre_zero, pre_overflow, dst_reg) hold.
REQ-026 With flush=1 at an edge: valid_out<=0, regwrite_out<=0 regardless of we and valid_in; data outputs hold; op_cnt unchanged.
REQ-027 With we=0 and flush=0: every output and op_cnt SHALL hold its value.
REQ-028 op_cnt SHALL increment by 1 on each accept and saturate at 16'hFFFF (no wrap).
REQ-029 Input values while valid_in=0 SHALL have no effect on any output.

Reset
REQ-030 While reset=0, all outputs (valid_out, regwrite_out, pre_m2result, pre_zero, pre_overflow, dst_reg, busy_dst, op_cnt) SHALL be 0 immediately, without waiting for clk.
REQ-031 Reset asserted mid-operation SHALL discard the in-flight op; first accept after release counts as op_cnt=1.
REQ-032 Reset SHALL take priority over we and flush.

Verification
REQ-033 pp_ll=15, others 0, neg_in=0, valid_in=1, regwrite=1, wreg_in=7, we=1 -> next edge: pre_m2result=15, pre_zero=0, pre_overflow=0, dst_reg=7, regwrite_out=1, busy_dst=1, op_cnt=1.
REQ-034 pp_hh=1, others 0, neg_in=0 (0x10000*0x10000) -> pre_m2result=0, pre_zero=1, pre_overflow=1.
REQ-035 pp_ll=6, neg_in=1 -> pre_m2result=32'hFFFFFFFA, pre_zero=0, pre_overflow=0; pp_hl=32'h00008000, others 0, neg_in=1 -> pre_m2result=32'h80000000, pre_overflow=0.
REQ-036 Valid op held with we=0 for 3 edges while inputs change -> all outputs and op_cnt unchanged; we=1 again -> new op captured next edge.
REQ-037 flush=1 with valid_in=1, we=1 -> valid_out=0, regwrite_out=0, busy_dst=0, pre_m2result unchanged, op_cnt unchanged; op_cnt preloaded to 16'hFFFF by 65535 accepts then one more accept -> stays 16'hFFFF.
REQ-038 reset driven low between edges while valid_out=1 -> all outputs 0 before next edge; after release, idle edges (valid_in=0) keep valid_out=0.

Source files
------------

// File: rtl/mult_m2.sv
// Second multiply pipeline stage: combines four 16x16 partial products into the signed
// 2*DATA_W-bit product. Registers the low word, zero/overflow flags and the
// destination-register tag for M3.
module mult_m2 #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              regwrite_mult_in,
    input  logic [ADDR_W-1:0] wreg_in,
    input  logic [DATA_W-1:0] pp_ll,
    input  logic [DATA_W-1:0] pp_lh,
    input  logic [DATA_W-1:0] pp_hl,
    input  logic [DATA_W-1:0] pp_hh,
    input  logic              neg_in,
    output logic              valid_out,
    output logic              regwrite_out,
    output logic [DATA_W-1:0] pre_m2result,
    output logic              pre_zero,
    output logic              pre_overflow,
    output logic [ADDR_W-1:0] dst_reg,
    output logic              busy_dst,
    output logic [15:0]       op_cnt
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned HALF_W = DATA_W / 2;
    localparam int unsigned CNT_W  = 16;

    logic [DATA_W:0]   mid_c;
    logic [PROD_W-1:0] mag_c;
    logic [PROD_W-1:0] full_c;
    logic              zero_c;
    logic              ovf_c;
    logic              accept_c;
    logic              kill_c;

    logic              valid_q,  valid_d;
    logic              rw_q,     rw_d;
    logic              busy_q,   busy_d;
    logic [DATA_W-1:0] res_q,    res_d;
    logic              zero_q,   zero_d;
    logic              ovf_q,    ovf_d;
    logic [ADDR_W-1:0] dst_q,    dst_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    // Product assembly; the middle sum keeps its carry bit before shifting.
    always_comb begin
        mid_c  = {1'b0, pp_lh} + {1'b0, pp_hl};
        mag_c  = {pp_hh, {DATA_W{1'b0}}}
               + (PROD_W'(mid_c) << HALF_W)
               + PROD_W'(pp_ll);
        full_c = neg_in ? (~mag_c + PROD_W'(1)) : mag_c;
        zero_c = (full_c[DATA_W-1:0] == '0);
        ovf_c  = (full_c[PROD_W-1:DATA_W] != {DATA_W{full_c[DATA_W-1]}});
    end

    // Flush dominates: it kills the entering op even while stalled.
    always_comb begin
        accept_c = we & valid_in & ~flush;
        kill_c   = flush | (we & ~valid_in);

        valid_d = valid_q;
        rw_d    = rw_q;
        busy_d  = busy_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;

        if (accept_c) begin
            valid_d = 1'b1;
            rw_d    = regwrite_mult_in;
            busy_d  = regwrite_mult_in;
            res_d   = full_c[DATA_W-1:0];
            zero_d  = zero_c;
            ovf_d   = ovf_c;
            dst_d   = wreg_in;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (kill_c) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dst_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_out    = valid_q;
    assign regwrite_out = rw_q;
    assign busy_dst     = busy_q;
    assign pre_m2result = res_q;
    assign pre_zero     = zero_q;
    assign pre_overflow = ovf_q;
    assign dst_reg      = dst_q;
    assign op_cnt       = cnt_q;

endmodule

// File: tb/tb_mult_m2.sv
// Scoreboard bench for mult_m2: expected results come from real signed multiplies of the
// operands, or from the shift-and-add sum of raw partial products.
module tb_mult_m2;

    typedef struct packed {
        logic [31:0] ll;
        logic [31:0] lh;
        logic [31:0] hl;
        logic [31:0] hh;
        logic        neg;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } op_t;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic [4:0]  dst;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic        regwrite_mult_in = 1'b0;
    logic [4:0]  wreg_in = '0;
    logic [31:0] pp_ll = '0, pp_lh = '0, pp_hl = '0, pp_hh = '0;
    logic        neg_in = 1'b0;
    logic        valid_out, regwrite_out, pre_zero, pre_overflow, busy_dst;
    logic [31:0] pre_m2result;
    logic [4:0]  dst_reg;
    logic [15:0] op_cnt;

    int checks = 0;
    int errors = 0;

    sb_t         sb[$];
    sb_t         m_data = '0;
    logic        m_valid = 1'b0;
    logic        m_rw = 1'b0;
    logic [15:0] m_cnt = '0;

    mult_m2 #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .we(we), .flush(flush), .valid_in(valid_in),
        .regwrite_mult_in(regwrite_mult_in), .wreg_in(wreg_in),
        .pp_ll(pp_ll), .pp_lh(pp_lh), .pp_hl(pp_hl), .pp_hh(pp_hh), .neg_in(neg_in),
        .valid_out(valid_out), .regwrite_out(regwrite_out), .pre_m2result(pre_m2result),
        .pre_zero(pre_zero), .pre_overflow(pre_overflow), .dst_reg(dst_reg),
        .busy_dst(busy_dst), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    // Partial products of operand magnitudes; expectation from a true signed multiply.
    function automatic op_t mk_ops(input logic [31:0] a, input logic [31:0] b);
        op_t         o;
        logic [31:0] ma, mb;
        logic [63:0] p;
        ma = a[31] ? (~a + 32'd1) : a;
        mb = b[31] ? (~b + 32'd1) : b;
        o.ll  = {16'd0, ma[15:0]}  * {16'd0, mb[15:0]};
        o.lh  = {16'd0, ma[15:0]}  * {16'd0, mb[31:16]};
        o.hl  = {16'd0, ma[31:16]} * {16'd0, mb[15:0]};
        o.hh  = {16'd0, ma[31:16]} * {16'd0, mb[31:16]};
        o.neg = a[31] ^ b[31];
        p     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        o.res  = p[31:0];
        o.zero = (p[31:0] == 32'd0);
        o.ovf  = (p[63:32] != {32{p[31]}});
        return o;
    endfunction

    // Raw partial products, expectation from a 64-bit shift-and-add.
    function automatic op_t mk_raw(input logic [31:0] ll, input logic [31:0] lh,
                                   input logic [31:0] hl, input logic [31:0] hh,
                                   input logic neg);
        op_t         o;
        logic [63:0] mag, full;
        o.ll = ll; o.lh = lh; o.hl = hl; o.hh = hh; o.neg = neg;
        mag  = ({32'd0, hh} << 32) + ({32'd0, lh} << 16) + ({32'd0, hl} << 16) + {32'd0, ll};
        full = neg ? (64'd0 - mag) : mag;
        o.res  = full[31:0];
        o.zero = (full[31:0] == 32'd0);
        o.ovf  = (full[63:32] != {32{full[31]}});
        return o;
    endfunction

    function automatic logic [57:0] dut_vec();
        return {valid_out, regwrite_out, busy_dst, dst_reg, pre_m2result,
                pre_zero, pre_overflow, op_cnt};
    endfunction

    function automatic logic [57:0] model_vec();
        return {m_valid, m_rw, m_valid & m_rw, m_data.dst, m_data.res,
                m_data.zero, m_data.ovf, m_cnt};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_rw = 1'b0; m_cnt = '0; m_data = '0;
        sb.delete();
    endtask

    // Drive one edge; push on accept, pop once the stage register has produced it.
    task automatic apply(input logic w, input logic f, input logic v, input logic r,
                         input logic [4:0] wr, input op_t op);
        sb_t e;
        we = w; flush = f; valid_in = v; regwrite_mult_in = r; wreg_in = wr;
        pp_ll = op.ll; pp_lh = op.lh; pp_hl = op.hl; pp_hh = op.hh; neg_in = op.neg;
        @(posedge clk);
        if (w && v && !f) begin
            e.res = op.res; e.zero = op.zero; e.ovf = op.ovf; e.dst = wr;
            sb.push_back(e);
            m_valid = 1'b1;
            m_rw    = r;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (f || (w && !v)) begin
            m_valid = 1'b0;
            m_rw    = 1'b0;
        end
        #1;
        if (sb.size() != 0) m_data = sb.pop_front();
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 58'd0) begin
            errors++;
            $display("FAIL reset_state got %h want %h", dut_vec(), 58'd0);
        end
        #1 reset = 1'b1;
    endtask

    task automatic test_basic();
        apply(1, 0, 1, 1, 5'd7, mk_ops(32'd15, 32'd1));
        checks++;
        if (dut_vec() !== model_vec() || pre_m2result !== 32'd15 || op_cnt !== 16'd1
            || busy_dst !== 1'b1 || dst_reg !== 5'd7) begin
            errors++;
            $display("FAIL basic got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_products();
        op_t ops[8];
        ops[0] = mk_ops(32'h0001_0000, 32'h0001_0000);
        ops[1] = mk_ops(-32'sd6, 32'd1);
        ops[2] = mk_ops(32'h8000_0000, 32'd1);
        ops[3] = mk_ops(32'h8000_0000, 32'h8000_0000);
        ops[4] = mk_ops(32'd0, 32'hFFFF_FFFF);
        ops[5] = mk_raw(32'd5, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0);
        ops[6] = mk_raw(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        ops[7] = mk_ops(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) begin
            apply(1, 0, 1, i[0], 5'(i + 3), ops[i]);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL product_%0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            apply(1, 0, 1, 1'($urandom), 5'($urandom),
                  mk_ops((i % 6 == 0) ? 32'd0 : $urandom, $urandom));
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL b2b_%0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_idle();
        apply(1, 0, 1, 1, 5'd9, mk_ops(32'd1234, -32'sd77));
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 1, 5'($urandom), mk_ops($urandom, $urandom));
            checks++;
            if (dut_vec() !== model_vec() || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL idle_%0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_stall();
        apply(1, 0, 1, 1, 5'd12, mk_ops(32'd300, 32'd300));
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1'(i != 1), 1'(i), 5'($urandom), mk_ops($urandom, $urandom));
            checks++;
            if (dut_vec() !== model_vec() || valid_out !== 1'b1) begin
                errors++;
                $display("FAIL stall_%0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
        apply(1, 0, 1, 0, 5'd21, mk_ops(-32'sd5, 32'd9));
        checks++;
        if (dut_vec() !== model_vec() || dst_reg !== 5'd21) begin
            errors++;
            $display("FAIL stall_release got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_flush();
        apply(1, 0, 1, 1, 5'd4, mk_ops(32'd99, 32'd3));
        apply(1, 1, 1, 1, 5'd30, mk_ops(32'd7, 32'd7));
        checks++;
        if (dut_vec() !== model_vec() || busy_dst !== 1'b0) begin
            errors++;
            $display("FAIL flush_we got %h want %h", dut_vec(), model_vec());
        end
        apply(1, 0, 1, 1, 5'd6, mk_ops(32'd11, 32'd13));
        apply(0, 1, 1, 1, 5'd31, mk_ops(32'd2, 32'd2));
        checks++;
        if (dut_vec() !== model_vec() || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_reset_mid();
        apply(1, 0, 1, 1, 5'd17, mk_ops(32'd50, 32'd60));
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== 58'd0) begin
            errors++;
            $display("FAIL reset_mid got %h want %h", dut_vec(), 58'd0);
        end
        #2 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, 0, 1, 5'd3, mk_ops($urandom, $urandom));
            checks++;
            if (dut_vec() !== model_vec() || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle_%0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
        apply(1, 0, 1, 1, 5'd8, mk_ops(32'd2, 32'd3));
        checks++;
        if (dut_vec() !== model_vec() || op_cnt !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_cnt got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_saturate();
        op_t o;
        o = mk_ops(32'd3, 32'd5);
        #2 reset = 1'b0;
        #1 model_reset();
        #2 reset = 1'b1;
        for (int i = 0; i < 65535; i++) apply(1, 0, 1, 0, 5'd1, o);
        checks++;
        if (dut_vec() !== model_vec() || op_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_preload got %h want %h", dut_vec(), model_vec());
        end
        apply(1, 0, 1, 1, 5'd2, mk_ops(32'd8, 32'd8));
        checks++;
        if (dut_vec() !== model_vec() || op_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_saturate got %h want %h", dut_vec(), model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_products();
        test_back_to_back();
        test_idle();
        test_stall();
        test_flush();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
